// File: rtl/qam_symbol_packer_if.sv
// Byte-in / symbol-out handshake bundle for the QAM symbol packer.
// The slave modport is the packer side; the master modport is the producer/consumer side.
interface qam_symbol_packer_if #(
   parameter int IN_WIDTH = 8,
   parameter int BPS      = 4
);
   logic [IN_WIDTH-1:0] in_data;
   logic                in_valid;
   logic                in_last;
   logic                in_ready;
   logic [BPS-1:0]      out_data;
   logic                out_valid;
   logic                out_last;
   logic                out_ready;

   modport slave (
      input  in_data, in_valid, in_last, out_ready,
      output in_ready, out_data, out_valid, out_last
   );

   modport master (
      output in_data, in_valid, in_last, out_ready,
      input  in_ready, out_data, out_valid, out_last
   );
endinterface

// File: rtl/qam_symbol_packer.sv
// Repacks IN_WIDTH-bit words LSB-first into BPS-bit symbols; first symbol is valid the cycle after accept, state holds under backpressure.
// Optional frame flush of a zero-padded residual symbol is enabled by defining QAM_PACK_FLUSH_EN.
module qam_symbol_packer #(
   parameter int POINTS   = 16,
   parameter int IN_WIDTH = 8
) (
   input logic                i_clk,
   input logic                i_rst,
   qam_symbol_packer_if.slave bus
);
   localparam int BPS   = $clog2(POINTS);
   localparam int ACC_W = IN_WIDTH + BPS - 1;
   localparam int CNT_W = $clog2(ACC_W + 1);

   localparam logic [CNT_W-1:0] C_BPS = CNT_W'(BPS);
   localparam logic [CNT_W-1:0] C_INW = CNT_W'(IN_WIDTH);

   logic [ACC_W-1:0] r_acc;
   logic [CNT_W-1:0] r_cnt;

   logic             w_in_ready;
   logic             w_out_valid;
   logic             w_out_last;
   logic             w_in_fire;
   logic             w_out_fire;
   logic [ACC_W-1:0] w_in_ext;

`ifdef QAM_PACK_FLUSH_EN
   logic r_flush;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_flush <= 1'b0;
      end else if (w_in_fire && bus.in_last) begin
         r_flush <= 1'b1;
      end else if (w_out_fire && w_out_last) begin
         r_flush <= 1'b0;
      end
   end

   assign w_in_ready  = (r_cnt < C_BPS) && !r_flush;
   assign w_out_valid = (r_cnt >= C_BPS) || (r_flush && (r_cnt != '0));
   assign w_out_last  = r_flush && (r_cnt <= C_BPS) && (r_cnt != '0);
`else
   logic w_unused_last;

   assign w_unused_last = bus.in_last;
   assign w_in_ready    = (r_cnt < C_BPS);
   assign w_out_valid   = (r_cnt >= C_BPS);
   assign w_out_last    = 1'b0;
`endif

   assign w_in_fire  = bus.in_valid && w_in_ready;
   assign w_out_fire = w_out_valid && bus.out_ready;
   assign w_in_ext   = {{(BPS-1){1'b0}}, bus.in_data};

   // Bits of r_acc at and above r_cnt are always zero, so OR-ing the shifted word places it at acc[cnt +: IN_WIDTH].
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_acc <= '0;
         r_cnt <= '0;
      end else if (w_in_fire) begin
         r_acc <= r_acc | (w_in_ext << r_cnt);
         r_cnt <= r_cnt + C_INW;
      end else if (w_out_fire) begin
         r_acc <= r_acc >> BPS;
         r_cnt <= (r_cnt >= C_BPS) ? (r_cnt - C_BPS) : '0;
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.out_last  = w_out_last;
   assign bus.out_data  = r_acc[BPS-1:0];
endmodule
